// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Memory wait sequencer states
  typedef logic [0:0] mem_state_t;
  localparam mem_state_t RUN  = 1'b0;
  localparam mem_state_t WAIT = 1'b1;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: adds one per cycle on inc, holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I core: forwarding, load-use stall,
// branch flush, data-memory wait sequencing and performance counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemAbortM,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  mem_state_t state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       lw_stall, timeout_hit, mem_freeze;
  fwd_sel_t   fwd_a, fwd_b;

  always_comb begin
    fwd_a = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
      fwd_a = FWD_MEM;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
      fwd_a = FWD_WB;
    end
    fwd_b = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
      fwd_b = FWD_MEM;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
      fwd_b = FWD_WB;
    end
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == WaitLast);
  assign mem_freeze  = MemReqM && !MemAckM && !timeout_hit;
  // An ack on the timeout cycle wins over the abort
  assign MemAbortM   = timeout_hit && !MemAckM;

  // Freeze dominates; a redirect seen while frozen is applied once E moves again
  assign StallF = mem_freeze | lw_stall;
  assign StallD = mem_freeze | lw_stall;
  assign StallE = mem_freeze;
  assign StallM = mem_freeze;
  assign FlushW = mem_freeze;
  assign FlushD = PCSrcE & ~mem_freeze;
  assign FlushE = (lw_stall | PCSrcE) & ~mem_freeze;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q == RUN) begin
      if (MemReqM && !MemAckM) begin
        state_d    = WAIT;
        wait_cnt_d = 8'd0;
      end
    end else begin
      if (MemAckM || timeout_hit) begin
        state_d = RUN;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (MemAbortM) begin
        mem_err <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (StallF),
    .count(stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (PCSrcE & ~mem_freeze),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_hazard_ctrl_unit;

  localparam int unsigned T    = 4;
  localparam int unsigned CW   = 5;
  localparam int          MAXC = 31;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic RegWriteM = 0, RegWriteW = 0, PCSrcE = 0, MemReqM = 0, MemAckM = 0;
  logic [1:0] ResultSrcE = '0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemAbortM, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .MEM_TIMEOUT(T),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ResultSrcE(ResultSrcE),
    .PCSrcE    (PCSrcE),
    .MemReqM   (MemReqM),
    .MemAckM   (MemAckM),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .MemAbortM (MemAbortM),
    .mem_err   (mem_err),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_age: cycles the current access has spent waiting, -1 when not waiting
  int m_age   = -1;
  bit m_err   = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic int m_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  function automatic bit m_lw();
    return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic bit m_to();
    return m_age >= 0 && m_age == int'(T) - 1;
  endfunction

  function automatic bit m_fz();
    return MemReqM && !MemAckM && !m_to();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age = -1; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if ((m_fz() || m_lw()) && m_stall < MAXC) m_stall++;
      if (PCSrcE && !m_fz() && m_flush < MAXC) m_flush++;
      if (m_to() && !MemAckM) m_err = 1;
      if (m_age < 0) begin
        if (MemReqM && !MemAckM) m_age = 0;
      end else if (MemAckM || m_to()) begin
        m_age = -1;
      end else begin
        m_age++;
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("m.StallF", StallF, m_fz() | m_lw());
      chk("m.StallD", StallD, m_fz() | m_lw());
      chk("m.StallE", StallE, m_fz());
      chk("m.StallM", StallM, m_fz());
      chk("m.FlushW", FlushW, m_fz());
      chk("m.FlushD", FlushD, PCSrcE && !m_fz());
      chk("m.FlushE", FlushE, (m_lw() || PCSrcE) && !m_fz());
      chk("m.ForwardAE", ForwardAE, m_fwd(Rs1E));
      chk("m.ForwardBE", ForwardBE, m_fwd(Rs2E));
      chk("m.MemAbortM", MemAbortM, m_to() && !MemAckM);
      chk("m.mem_err", mem_err, m_err);
      chk("m.stall_cnt", stall_cnt, m_stall);
      chk("m.flush_cnt", flush_cnt, m_flush);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM} = '0;
    ResultSrcE = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_freeze(input string tag, input logic f);
    chk({tag, ".StallF"}, StallF, f);
    chk({tag, ".StallE"}, StallE, f);
    chk({tag, ".StallM"}, StallM, f);
    chk({tag, ".FlushW"}, FlushW, f);
  endtask

  initial begin
    chk_en = 1;
    tick();
    chk("rst.StallF", StallF, 0);
    chk("rst.FlushE", FlushE, 0);
    chk("rst.mem_err", mem_err, 0);
    chk("rst.stall_cnt", stall_cnt, 0);
    do_reset();

    // forwarding priority
    Rs1E = 5; Rs2E = 9; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #1 chk("fwd.mem", ForwardAE, 2'b10);
    chk("fwd.b_rf", ForwardBE, 2'b00);
    RegWriteM = 0;
    #1 chk("fwd.wb", ForwardAE, 2'b01);
    RegWriteM = 1; RdM = 0; RdW = 0;
    #1 chk("fwd.x0", ForwardAE, 2'b00);
    clear_inputs();

    // load-use
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    @(negedge clk);
    chk("lw.StallF", StallF, 1);
    chk("lw.StallD", StallD, 1);
    chk("lw.FlushE", FlushE, 1);
    chk("lw.FlushD", FlushD, 0);
    chk("lw.StallE", StallE, 0);
    tick();
    chk("lw.stall_cnt", stall_cnt, 1);
    RdE = 0;
    #1 chk("lw.x0", StallF, 0);
    clear_inputs();

    // branch flush
    PCSrcE = 1;
    @(negedge clk);
    chk("br.FlushD", FlushD, 1);
    chk("br.FlushE", FlushE, 1);
    tick();
    chk("br.flush_cnt", flush_cnt, 1);
    clear_inputs();

    // memory wait with deferred redirect
    do_reset();
    MemReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_freeze("mw", 1);
      chk("mw.FlushD", FlushD, 0);
      chk("mw.FlushE", FlushE, 0);
      tick();
    end
    MemAckM = 1;
    @(negedge clk);
    chk_freeze("mwack", 0);
    chk("mwack.FlushD", FlushD, 1);
    chk("mwack.FlushE", FlushE, 1);
    tick();
    chk("mw.stall_cnt", stall_cnt, 3);
    chk("mw.flush_cnt", flush_cnt, 1);
    clear_inputs();

    // timeout and sticky error
    do_reset();
    MemReqM = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_freeze("to", 1);
      chk("to.abort", MemAbortM, 0);
      tick();
    end
    @(negedge clk);
    chk_freeze("to.rel", 0);
    chk("to.abort_hit", MemAbortM, 1);
    tick();
    chk("to.mem_err", mem_err, 1);
    chk("to.stall_cnt", stall_cnt, 4);
    MemReqM = 0;
    tick(); tick();
    chk("to.sticky", mem_err, 1);

    // ack on the timeout cycle
    do_reset();
    MemReqM = 1;
    repeat (4) tick();
    MemAckM = 1;
    @(negedge clk);
    chk("toack.abort", MemAbortM, 0);
    tick();
    chk("toack.mem_err", mem_err, 0);
    clear_inputs();

    // reset in the middle of a wait
    do_reset();
    MemReqM = 1;
    repeat (2) tick();
    reset = 1'b1;
    #1 chk("rmw.abort", MemAbortM, 0);
    clear_inputs();
    #1 chk("rmw.StallF", StallF, 0);
    chk("rmw.stall_cnt", stall_cnt, 0);
    chk("rmw.mem_err", mem_err, 0);
    tick();
    reset = 1'b0;
    MemReqM = 1;
    repeat (2) tick();
    @(negedge clk);
    chk("rmw.run", MemAbortM, 0);
    chk("rmw.frozen", StallF, 1);
    tick();
    clear_inputs();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      Rs1D = 5'($urandom_range(0, 3));
      Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3));
      Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3));
      RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      if (m_age >= 0) MemReqM = ($urandom_range(0, 9) != 0);
      else MemReqM = ($urandom_range(0, 2) == 0);
      MemAckM = ($urandom_range(0, 4) == 0);
      tick();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
